// File: rtl/fc_module.sv
// fc_module: serial 27-element fully-connected layer, N_OUT parallel signed MACs, requantised to u8
module fc_module #(
  parameter int N_OUT = 10,
  parameter int SHIFT = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld,
  input  logic [215:0]           pool_lin,
  input  logic [N_OUT*216-1:0]   w_lin,
  input  logic [N_OUT*8-1:0]     b_lin,
  output logic [N_OUT*8-1:0]     fc_lin,
  output logic                   out_vld,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [215:0] x_reg;
  logic [7:0] base;
  logic signed [8:0] xs;
  logic [N_OUT*8-1:0] y;
  logic start;
  assign base = {cnt, 3'b000};
  assign xs = {1'b0, x_reg[base +: 8]};
  assign start = state == IDLE && in_vld;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? (in_vld ? MAC : IDLE) :
               state == MAC  ? (cnt == 5'd26 ? OUT : MAC) : IDLE;
  end
  for (genvar o = 0; o < N_OUT; o++) begin : g_n
    logic signed [7:0] ws, bs;
    logic signed [16:0] prod;
    logic signed [23:0] acc, sh;
    assign ws = w_lin[o*216 + base +: 8];
    assign bs = b_lin[o*8 +: 8];
    assign prod = 17'(xs) * 17'(ws);
    assign sh = acc >>> SHIFT;
    // negative sums clamp to zero, so ReLU comes for free
    assign y[o*8 +: 8] = sh[23] ? 8'd0 : (|sh[22:8]) ? 8'hff : sh[7:0];
    always_ff @(posedge clk) begin
      if (!rst_n) acc <= '0;
      else if (start) acc <= 24'(bs);
      else if (state == MAC) acc <= acc + 24'(prod);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      x_reg <= '0;
      fc_lin <= '0;
      out_vld <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == MAC ? cnt + 5'd1 : 5'd0;
      out_vld <= state == OUT;
      if (start) x_reg <= pool_lin;
      if (state == OUT) fc_lin <= y;
    end
  end
endmodule

// File: tb/tb_fc_module.sv
// tb_fc_module: directed vector table plus drop/reset sequences for fc_module
module tb_fc_module;
  localparam int N = 10;
  localparam int W = N * 216;
  logic clk = 1'b0, rst_n = 1'b0, in_vld = 1'b0;
  logic [215:0] pool_lin = '0;
  logic [W-1:0] w_lin = '0;
  logic [N*8-1:0] b_lin = '0;
  logic [N*8-1:0] fc_lin;
  logic out_vld, busy;
  int n_cmp = 0, n_bad = 0;

  fc_module #(.N_OUT(N), .SHIFT(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .pool_lin(pool_lin),
    .w_lin(w_lin), .b_lin(b_lin), .fc_lin(fc_lin), .out_vld(out_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    string name;
    logic [215:0] x;
    logic [W-1:0] w;
    logic [N*8-1:0] b;
    logic [N*8-1:0] y;
  } vec_t;
  vec_t v[6];

  function automatic logic [215:0] fill_x(input int val);
    logic [215:0] r;
    for (int e = 0; e < 27; e++) r[8*e +: 8] = 8'(val);
    return r;
  endfunction

  function automatic logic [W-1:0] fill_w(input int val);
    logic [W-1:0] r;
    for (int i = 0; i < N*27; i++) r[8*i +: 8] = 8'(val);
    return r;
  endfunction

  function automatic logic [N*8-1:0] fill_n(input int val);
    logic [N*8-1:0] r;
    for (int o = 0; o < N; o++) r[8*o +: 8] = 8'(val);
    return r;
  endfunction

  task automatic check(input string name, input logic [N*8-1:0] act, input logic [N*8-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    pool_lin = t.x;
    w_lin = t.w;
    b_lin = t.b;
  endtask

  task automatic pulse();
    @(negedge clk) in_vld = 1'b1;
    @(negedge clk) in_vld = 1'b0;
  endtask

  task automatic run_vec(input vec_t t);
    int lat;
    apply(t);
    pulse();
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) check({t.name, "_busy_first"}, 80'(busy), 80'(1));
      if (k == 27) check({t.name, "_busy_last"}, 80'(busy), 80'(1));
      if (out_vld) begin
        lat = k;
        break;
      end
    end
    check({t.name, "_latency"}, 80'(lat), 80'(28));
    check({t.name, "_y"}, fc_lin, t.y);
    check({t.name, "_busy_done"}, 80'(busy), 80'(0));
    @(posedge clk); #1;
    check({t.name, "_vld_pulse"}, 80'(out_vld), 80'(0));
  endtask

  initial begin
    int seen, k1, k2;
    logic [N*8-1:0] y1;
    v[0] = '{"ones", fill_x(128), fill_w(1), fill_n(0), fill_n(27)};
    v[1] = '{"sat_hi", fill_x(255), fill_w(127), fill_n(127), fill_n(255)};
    v[2] = '{"sat_lo", fill_x(255), fill_w(-128), fill_n(127), fill_n(0)};
    v[3] = '{"neg_bias", fill_x(0), fill_w(1), fill_n(-128), fill_n(0)};
    v[4] = '{"diag", '0, '0, fill_n(0), '0};
    v[5] = '{"ramp", fill_x(100), '0, fill_n(0), '0};
    for (int e = 0; e < 27; e++) v[4].x[8*e +: 8] = 8'(8 * e);
    for (int o = 0; o < N; o++) begin
      v[4].w[(o*27 + o)*8 +: 8] = 8'd64;
      v[4].y[8*o +: 8] = 8'(4 * o);
      for (int e = 0; e < 27; e++) v[5].w[(o*27 + e)*8 +: 8] = 8'(o);
      v[5].y[8*o +: 8] = 8'((2700 * o) / 128);
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_fc", fc_lin, '0);
    check("reset_vld", 80'(out_vld), 80'(0));
    check("reset_busy", 80'(busy), 80'(0));
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check("idle_fc", fc_lin, '0);
      check("idle_ctl", 80'({out_vld, busy}), 80'(0));
    end

    for (int i = 0; i < 6; i++) run_vec(v[i]);

    // pulses at T+5 (MAC) and T+28 (OUT) must be dropped; T+29 starts a new run
    apply(v[0]);
    pulse();
    seen = 0; k1 = 0; k2 = 0; y1 = '0;
    for (int k = 1; k <= 60; k++) begin
      in_vld = (k == 5 || k == 28 || k == 29);
      if (k == 5 || k == 28) pool_lin = '0;
      if (k == 29) apply(v[4]);
      @(posedge clk); #1;
      if (out_vld) begin
        seen++;
        if (seen == 1) begin k1 = k; y1 = fc_lin; end
        if (seen == 2) k2 = k;
      end
    end
    in_vld = 1'b0;
    check("drop_count", 80'(seen), 80'(2));
    check("drop_first_at", 80'(k1), 80'(28));
    check("drop_first_y", y1, v[0].y);
    check("drop_second_at", 80'(k2), 80'(57));
    check("drop_second_y", fc_lin, v[4].y);

    // reset mid-run, with a coincident in_vld that reset must override
    apply(v[1]);
    pulse();
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) begin rst_n = 1'b0; in_vld = 1'b1; end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    in_vld = 1'b0;
    check("abort_fc", fc_lin, '0);
    check("abort_busy", 80'(busy), 80'(0));
    check("abort_vld", 80'(out_vld), 80'(0));
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_vld || busy) seen++;
    end
    check("abort_quiet", 80'(seen), 80'(0));
    run_vec(v[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
